sum_table_seq: RTL
==================

SUM_TABLE_SEQ -- requirements
Module: sum_table_seq

Interface
REQ-001 The block SHALL have parameter CHECK_EN, default 1; 1 = fill then read back and check, 0 = fill only.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port START, input, 1, run request; sampled only in IDLE.
REQ-005 The block SHALL have port RAM_CS, output, 1, chip select to the 256x5 sum RAM.
REQ-006 The block SHALL have port RAM_WE, output, 1, write enable to the RAM (1 = write, 0 = read).
REQ-007 The block SHALL have port RAM_ADDR, output, 8, RAM address {A,B}, with A = RAM_ADDR[7:4] and B = RAM_ADDR[3:0].
REQ-008 The block SHALL have port RAM_DIN, output, 5, write data = A+B.
REQ-009 The block SHALL have port RAM_DOUT, input, 5, registered RAM read data, valid the cycle after a read edge.
REQ-010 The block SHALL have port BUSY, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port DONE, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port ERR_CNT, output, 9, count of read-back mismatches (0..256).
REQ-013 The block SHALL have port ERR_FLAG, output, 1, at least one mismatch in the last run.
REQ-014 The block SHALL have port FIRST_ERR_ADDR, output, 8, address of the first mismatch in the last run.

Function
REQ-015 The FSM SHALL have states IDLE, FILL, CHECK, DRAIN, DONE; transitions IDLE->FILL on START, FILL->CHECK after address 255 (FILL->DONE if CHECK_EN=0), CHECK->DRAIN after address 255, DRAIN->DONE, DONE->IDLE unconditionally.
REQ-016 In IDLE, RAM_CS SHALL be 0, RAM_WE SHALL be 0 and RAM_ADDR SHALL be 0; RAM_DOUT SHALL be ignored.
REQ-017 An 8-bit address counter SHALL clear to 0 on entry to FILL and on entry to CHECK, and SHALL increment by 1 per cycle in those states, leaving the state when the counter is 255 (no wrap to 0 inside a phase).
REQ-018 In FILL, RAM_CS SHALL be 1, RAM_WE SHALL be 1, RAM_ADDR SHALL be the counter, and RAM_DIN SHALL be the zero-extended 5-bit sum counter[7:4]+counter[3:0] (maximum 15+15=30).
REQ-019 In CHECK, RAM_CS SHALL be 1, RAM_WE SHALL be 0, RAM_ADDR SHALL be the counter, and RAM_DIN SHALL be 0.
REQ-020 The read address and a read-valid bit SHALL be delayed one cycle; when the delayed valid is set (the cycle after each CHECK read, including the single DRAIN cycle), RAM_DOUT SHALL be compared to the expected sum of the delayed address.
REQ-021 On a mismatch, ERR_CNT SHALL increment by 1; on the first mismatch of a run, FIRST_ERR_ADDR SHALL take the delayed address and ERR_FLAG SHALL set.
REQ-022 In DRAIN, RAM_CS SHALL be 0.
REQ-023 Timing (start sampled at edge E0): writes SHALL occur at E1..E256, reads at E257..E512, the last compare at E513, and DONE SHALL be high for the one cycle after E513; with CHECK_EN=0, DONE SHALL be high for the one cycle after E256.
REQ-024 Entry to FILL SHALL clear ERR_CNT, ERR_FLAG and FIRST_ERR_ADDR; otherwise the results SHALL hold their values until the next START.
REQ-025 START while BUSY SHALL be ignored; START held high continuously SHALL launch a new run from each IDLE cycle.
REQ-026 ERR_CNT SHALL NOT wrap; 256 mismatches SHALL give 9'd256.

Reset
REQ-027 RST SHALL take priority over START and all state.
REQ-028 At the next edge with RST=1, the FSM SHALL go to IDLE, and RAM_CS, RAM_WE, RAM_ADDR, RAM_DIN, BUSY, DONE, ERR_CNT, ERR_FLAG and FIRST_ERR_ADDR SHALL all become 0.
REQ-029 RST asserted mid-FILL or mid-CHECK SHALL abort the run with no further RAM access; no DONE pulse SHALL occur for the aborted run.

Verification
REQ-030 Clean run: bench connects the sum RAM model, pulses START -> 256 writes with RAM[0x00]=0, RAM[0x23]=5, RAM[0x27]=9, RAM[0xFF]=30; DONE high 513 cycles after start; ERR_CNT=0; ERR_FLAG=0.
REQ-031 Fault injection: bench forces the RAM model to return 5'd7 for address 0x23 -> ERR_CNT=1, ERR_FLAG=1, FIRST_ERR_ADDR=0x23.
REQ-032 All-fail: bench forces RAM_DOUT stuck at 5'd31 -> ERR_CNT=256, FIRST_ERR_ADDR=0x00.
REQ-033 CHECK_EN=0: bench pulses START -> no cycle with RAM_WE=0 and RAM_CS=1; DONE high 256 cycles after start; ERR_CNT=0.
REQ-034 Busy and back-to-back: bench pulses START again at cycle 100 of a run -> run is unaffected with a single DONE; START held high -> second run begins the cycle after DONE, and the previous results are cleared on FILL entry.
REQ-035 Reset mid-run: bench asserts RST at cycle 300 (CHECK) -> BUSY=0 and RAM_CS=0 the next cycle, no DONE pulse; a fresh START then completes normally.

Source files
------------

// File: rtl/sum_table_seq.sv
// sum_table_seq: fills a 256x5 RAM with A+B for every address {A,B}, then
// (when CHECK_EN is set) reads the table back and counts read-back mismatches.
module sum_table_seq #(
   parameter int CHECK_EN = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   output logic       RAM_CS,
   output logic       RAM_WE,
   output logic [7:0] RAM_ADDR,
   output logic [4:0] RAM_DIN,
   input  logic [4:0] RAM_DOUT,
   output logic       BUSY,
   output logic       DONE,
   output logic [8:0] ERR_CNT,
   output logic       ERR_FLAG,
   output logic [7:0] FIRST_ERR_ADDR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CHECK,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       rd_vld_q, rd_vld_d;
   logic [7:0] rd_addr_q, rd_addr_d;
   logic [8:0] err_cnt_q, err_cnt_d;
   logic       err_flag_q, err_flag_d;
   logic [7:0] first_err_q, first_err_d;
   logic       mismatch;

   // Table entry for address {a,b}: zero-extended a+b, at most 30.
   function automatic logic [4:0] sum_of(input logic [7:0] addr);
      return {1'b0, addr[7:4]} + {1'b0, addr[3:0]};
   endfunction

   // Next-state and address counter; the counter restarts at 0 on entry to
   // each phase and the phase ends on 255 rather than wrapping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_FILL;
               cnt_d   = 8'd0;
            end
         end
         S_FILL: begin
            if (cnt_q == 8'hFF) begin
               if (CHECK_EN != 0) state_d = S_CHECK;
               else               state_d = S_DONE;
               cnt_d = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_CHECK: begin
            if (cnt_q == 8'hFF) begin
               state_d = S_DRAIN;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // RAM strobes and status decode straight from state and counter.
   always_comb begin
      RAM_CS   = 1'b0;
      RAM_WE   = 1'b0;
      RAM_ADDR = 8'd0;
      RAM_DIN  = 5'd0;
      BUSY     = (state_q != S_IDLE);
      DONE     = (state_q == S_DONE);
      if (state_q == S_FILL) begin
         RAM_CS   = 1'b1;
         RAM_WE   = 1'b1;
         RAM_ADDR = cnt_q;
         RAM_DIN  = sum_of(cnt_q);
      end else if (state_q == S_CHECK) begin
         RAM_CS   = 1'b1;
         RAM_ADDR = cnt_q;
      end
   end

   // Read data returns one cycle after the read edge, so the address and a
   // valid bit are carried alongside; DRAIN exists only to catch the last one.
   always_comb begin
      rd_vld_d  = (state_q == S_CHECK);
      rd_addr_d = cnt_q;
      mismatch  = rd_vld_q && (RAM_DOUT != sum_of(rd_addr_q));
   end

   // Error bookkeeping: cleared when a run launches, otherwise held.
   always_comb begin
      err_cnt_d   = err_cnt_q;
      err_flag_d  = err_flag_q;
      first_err_d = first_err_q;
      if (state_q == S_IDLE && START) begin
         err_cnt_d   = 9'd0;
         err_flag_d  = 1'b0;
         first_err_d = 8'd0;
      end else if (mismatch) begin
         if (err_cnt_q != 9'd256) err_cnt_d = err_cnt_q + 9'd1;
         if (!err_flag_q) begin
            err_flag_d  = 1'b1;
            first_err_d = rd_addr_q;
         end
      end
   end

   assign ERR_CNT        = err_cnt_q;
   assign ERR_FLAG       = err_flag_q;
   assign FIRST_ERR_ADDR = first_err_q;

   // State registers; reset wins over everything and aborts any run.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         rd_vld_q    <= 1'b0;
         rd_addr_q   <= 8'd0;
         err_cnt_q   <= 9'd0;
         err_flag_q  <= 1'b0;
         first_err_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_vld_q    <= rd_vld_d;
         rd_addr_q   <= rd_addr_d;
         err_cnt_q   <= err_cnt_d;
         err_flag_q  <= err_flag_d;
         first_err_q <= first_err_d;
      end
   end

endmodule
